ex_branch_stage: RTL and testbench
==================================

Name: ex_branch_stage

Overview:
- Execute→memory boundary stage placed directly downstream of the core ALU.
- Consumes the ALU result and the zero/negative/carry_out/overflow flags, and resolves conditional branches and jumps.
- Issues a one-cycle fetch redirect and registers the instruction into a 2-entry skid buffer with valid/ready handshake toward the memory stage.

Parameters:
- XLEN, 64, datapath width (result, pc, target).
- REG_ADDR, 5, destination register index width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid EX instruction.
- in_ready  out  1  stage can accept this cycle.
- ula_y  in  XLEN  ALU result.
- ula_zero, ula_negative, ula_carry_out, ula_overflow  in  1 each  ALU flags; they are the subtraction flags when is_branch=1.
- funct3  in  3  branch condition.
- is_branch  in  1  conditional branch.
- is_jump  in  1  JAL/JALR.
- pc  in  XLEN  instruction address.
- target  in  XLEN  precomputed branch/jump target.
- rd  in  REG_ADDR  destination register.
- rd_we  in  1  destination write enable.
- flush  in  1  kill all held and incoming instructions (trap/later redirect).
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts head.
- out_result  out  XLEN  ula_y, or pc+4 for jumps.
- out_rd  out  REG_ADDR  registered rd.
- out_rd_we  out  1  registered rd_we; 0 for branches.
- redirect  out  1  one-cycle pulse: taken branch/jump accepted.
- redirect_pc  out  XLEN  target associated with redirect.
- illegal  out  1  one-cycle pulse: accepted branch with funct3 010/011.

Behaviour:
- Reset (reset=0, asynchronous): both entries invalid; out_valid=0, redirect=0, illegal=0, redirect_pc=0, out_result=0, out_rd=0, out_rd_we=0. in_ready=1 from the first edge after reset release.
- Accept: in_valid & in_ready & ~flush on a rising edge.
- Branch conditions on accept:
  - 000 BEQ: zero.
  - 001 BNE: ~zero.
  - 100 BLT: negative^overflow.
  - 101 BGE: ~(negative^overflow).
  - 110 BLTU: ~carry_out.
  - 111 BGEU: carry_out.
  - 010/011: not taken, illegal pulse.
- taken = is_jump | (is_branch & cond). If is_jump and is_branch are both 1, treat as jump.
- redirect and redirect_pc are registered: asserted the cycle after accept, for exactly one cycle. redirect_pc is held between pulses.
- Entry payload:
  - out_result = is_jump ? pc+4 (mod 2^XLEN) : ula_y.
  - out_rd_we = rd_we & ~is_branch.
  - out_rd = rd.
- Skid buffer:
  - States EMPTY (0 entries), ONE, FULL (2 entries); in_ready = (state != FULL), registered.
  - EMPTY + accept → ONE; latency is 1 cycle, so out_valid rises the edge after accept.
  - ONE + accept + out_ready → ONE (new entry becomes head).
  - ONE + accept + ~out_ready → FULL.
  - ONE + out_ready + no accept → EMPTY.
  - FULL + out_ready → ONE (skid entry promotes to head). No accept is possible in FULL.
  - Output payload remains stable while out_valid & ~out_ready.
- flush: next edge → EMPTY, the incoming instruction is dropped, redirect and illegal are forced to 0. If flush coincides with a would-be accept, flush wins.
- Wrap-around: pc+4 at pc = 2^XLEN−4 yields 0.
- Back-to-back taken branches: each produces its own pulse; consecutive cycles are allowed. This stage does not self-squash; fetch/decode kill wrong-path work via redirect.

Decomposition:
- Shared package:
  - funct3 branch encodings (BEQ..BGEU).
  - Skid state encoding EMPTY/ONE/FULL.
  - Entry payload field widths.
- One sub-module: branch_cond (combinational funct3 + flags → taken, illegal).
- Skid buffer stays in the top level.

Test Plan:
- Reset: hold reset=0 with in_valid=1 → out_valid=0, redirect=0, in_ready=1 one edge after release.
- BLT: pc=0x1000, target=0x0F00, funct3=100, negative=1, overflow=0 → redirect=1 with redirect_pc=0x0F00 for exactly one cycle; out_rd_we=0.
- BGEU not taken: funct3=111, carry_out=0 → redirect=0. funct3=011 → illegal=1 pulse, redirect=0.
- JAL link: is_jump=1, pc=0x2000, rd=1, rd_we=1 → out_result=0x2004, out_rd=1, redirect=1. With pc=0xFFFF_FFFF_FFFF_FFFC, out_result=0.
- Backpressure: out_ready=0, accept A then B → in_ready drops to 0, out_result=A stays stable. Raise out_ready → A then B delivered in order, in_ready returns to 1.
- Flush while FULL with in_valid=1 → out_valid=0 next cycle, input dropped, no redirect pulse.

Source files
------------

// File: rtl/ex_branch_stage_pkg.sv
// Shared definitions for the EX->MEM branch-resolution stage: branch encodings,
// skid-buffer state encoding and payload field widths.
package ex_branch_stage_pkg;

    localparam int XLEN_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int PC_STEP    = 4;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ex_branch_stage_branch_cond.sv
// Combinational branch-condition evaluation from funct3 and the ALU subtraction flags.
module branch_cond
    import ex_branch_stage_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry_out,
    input  logic       overflow,
    output logic       cond,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = negative ^ overflow;
            F3_BGE:  cond = ~(negative ^ overflow);
            // carry_out=1 on subtraction means no borrow, i.e. a >= b unsigned
            F3_BLTU: cond = ~carry_out;
            F3_BGEU: cond = carry_out;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_branch_stage.sv
// EX->MEM boundary stage: resolves branches/jumps, pulses a fetch redirect and
// holds results in a 2-entry skid buffer toward the memory stage.
module ex_branch_stage
    import ex_branch_stage_pkg::*;
#(
    parameter int XLEN     = XLEN_W,
    parameter int REG_ADDR = REG_ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     ula_y,
    input  logic                ula_zero,
    input  logic                ula_negative,
    input  logic                ula_carry_out,
    input  logic                ula_overflow,
    input  logic [2:0]          funct3,
    input  logic                is_branch,
    input  logic                is_jump,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     target,
    input  logic [REG_ADDR-1:0] rd,
    input  logic                rd_we,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [REG_ADDR-1:0] out_rd,
    output logic                out_rd_we,
    output logic                redirect,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                illegal
);

    typedef struct packed {
        logic [XLEN-1:0]     result;
        logic [REG_ADDR-1:0] rd;
        logic                rd_we;
    } entry_t;

    skid_state_e     state_q, state_d;
    entry_t          head_q, head_d;
    entry_t          skid_q, skid_d;
    entry_t          new_entry;
    logic            in_ready_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            illegal_q;

    logic            accept;
    logic            br_cond;
    logic            br_illegal;
    logic            taken;
    logic            illegal_d;

    branch_cond u_branch_cond (
        .funct3    (funct3),
        .zero      (ula_zero),
        .negative  (ula_negative),
        .carry_out (ula_carry_out),
        .overflow  (ula_overflow),
        .cond      (br_cond),
        .illegal   (br_illegal)
    );

    assign accept    = in_valid & in_ready_q & ~flush;
    // A jump wins over a simultaneously flagged branch.
    assign taken     = is_jump | (is_branch & br_cond);
    assign illegal_d = accept & is_branch & ~is_jump & br_illegal;

    always_comb begin
        new_entry.result = is_jump ? (pc + XLEN'(PC_STEP)) : ula_y;
        new_entry.rd     = rd;
        new_entry.rd_we  = rd_we & ~is_branch;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        head_d  = new_entry;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && out_ready) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = SKID_FULL;
                    end else if (out_ready) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_ready) begin
                        head_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= SKID_EMPTY;
            in_ready_q    <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_FULL);
            redirect_q <= accept & taken;
            illegal_q  <= illegal_d;
            if (accept && taken) begin
                redirect_pc_q <= target;
            end
        end
    end

    // NOTE: the two payload entries are reset too, so the output bus reads zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != SKID_EMPTY);
    assign out_result  = head_q.result;
    assign out_rd      = head_q.rd;
    assign out_rd_we   = head_q.rd_we;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_ex_branch_stage.sv
// Directed self-checking bench for ex_branch_stage.
module tb_ex_branch_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ula_y;
    logic        ula_zero, ula_negative, ula_carry_out, ula_overflow;
    logic [2:0]  funct3;
    logic        is_branch, is_jump;
    logic [63:0] pc, target;
    logic [4:0]  rd;
    logic        rd_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    ex_branch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ula_y         (ula_y),
        .ula_zero      (ula_zero),
        .ula_negative  (ula_negative),
        .ula_carry_out (ula_carry_out),
        .ula_overflow  (ula_overflow),
        .funct3        (funct3),
        .is_branch     (is_branch),
        .is_jump       (is_jump),
        .pc            (pc),
        .target        (target),
        .rd            (rd),
        .rd_we         (rd_we),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_rd_we     (out_rd_we),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .illegal       (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; is_branch = 1'b0; is_jump = 1'b0; funct3 = 3'b000;
        ula_zero = 1'b0; ula_negative = 1'b0; ula_carry_out = 1'b0; ula_overflow = 1'b0;
        ula_y = '0; pc = '0; target = '0; rd = '0; rd_we = 1'b0; flush = 1'b0;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic z, input logic n,
                                input logic c, input logic v, input logic [63:0] tgt);
        idle();
        in_valid = 1'b1; is_branch = 1'b1; funct3 = f3;
        ula_zero = z; ula_negative = n; ula_carry_out = c; ula_overflow = v;
        target = tgt; pc = 64'h1000; ula_y = 64'h55; rd = 5'd3; rd_we = 1'b1;
    endtask

    task automatic drive_alu(input logic [63:0] y, input logic [4:0] r);
        idle();
        in_valid = 1'b1; ula_y = y; rd = r; rd_we = 1'b1;
    endtask

    typedef struct {
        logic [2:0] f3;
        logic       z, n, c, v;
        logic       exp_taken;
    } cond_vec_t;

    cond_vec_t vecs[12];
    logic [63:0] last_target;

    initial begin
        vecs[0]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with a valid instruction presented
        idle();
        out_ready = 1'b1;
        reset = 1'b0;
        drive_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0F00);
        #22;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_redirect", redirect, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_redirect_pc", redirect_pc, 64'h0);
        check("rst_out_result", out_result, 64'h0);
        check("rst_out_rd", out_rd, 5'd0);
        check("rst_out_rd_we", out_rd_we, 1'b0);
        reset = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_out_valid", out_valid, 1'b0);
        check("rel_redirect", redirect, 1'b0);

        // BLT taken: one-cycle redirect, branch never writes rd
        drive_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0F00);
        tick();
        check("blt_redirect", redirect, 1'b1);
        check("blt_redirect_pc", redirect_pc, 64'h0F00);
        check("blt_out_valid", out_valid, 1'b1);
        check("blt_out_rd_we", out_rd_we, 1'b0);
        check("blt_out_result", out_result, 64'h55);
        idle();
        tick();
        check("blt_redirect_end", redirect, 1'b0);
        check("blt_redirect_pc_hold", redirect_pc, 64'h0F00);
        check("blt_drained", out_valid, 1'b0);
        last_target = 64'h0F00;

        // Condition table, back-to-back accepts
        for (int i = 0; i < 12; i++) begin
            drive_branch(vecs[i].f3, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v,
                         64'h100 * (i + 1));
            tick();
            if (vecs[i].exp_taken) last_target = 64'h100 * (i + 1);
            check($sformatf("cond%0d_redirect", i), redirect, vecs[i].exp_taken);
            check($sformatf("cond%0d_redirect_pc", i), redirect_pc, last_target);
            check($sformatf("cond%0d_illegal", i), illegal, 1'b0);
        end

        // Illegal funct3 011
        drive_branch(3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 64'h7000);
        tick();
        check("ill_pulse", illegal, 1'b1);
        check("ill_redirect", redirect, 1'b0);
        idle();
        tick();
        check("ill_end", illegal, 1'b0);

        // JAL link value, then pc+4 wrap-around
        idle();
        in_valid = 1'b1; is_jump = 1'b1; pc = 64'h2000; target = 64'h3000;
        rd = 5'd1; rd_we = 1'b1; ula_y = 64'hDEAD;
        tick();
        check("jal_result", out_result, 64'h2004);
        check("jal_rd", out_rd, 5'd1);
        check("jal_rd_we", out_rd_we, 1'b1);
        check("jal_redirect", redirect, 1'b1);
        check("jal_redirect_pc", redirect_pc, 64'h3000);
        pc = 64'hFFFF_FFFF_FFFF_FFFC; target = 64'h4000;
        tick();
        check("jal_wrap_result", out_result, 64'h0);
        check("jal_wrap_redirect", redirect, 1'b1);
        idle();
        tick();

        // Backpressure: A then B held, C refused while full
        out_ready = 1'b0;
        drive_alu(64'hAAAA, 5'd5);
        tick();
        check("bp_a_valid", out_valid, 1'b1);
        check("bp_a_result", out_result, 64'hAAAA);
        check("bp_a_in_ready", in_ready, 1'b1);
        drive_alu(64'hBBBB, 5'd6);
        tick();
        check("bp_full_in_ready", in_ready, 1'b0);
        check("bp_full_result", out_result, 64'hAAAA);
        check("bp_full_rd", out_rd, 5'd5);
        drive_alu(64'hCCCC, 5'd7);
        tick();
        check("bp_hold_result", out_result, 64'hAAAA);
        check("bp_hold_in_ready", in_ready, 1'b0);
        idle();
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", out_valid, 1'b1);
        check("bp_b_result", out_result, 64'hBBBB);
        check("bp_b_rd", out_rd, 5'd6);
        check("bp_b_in_ready", in_ready, 1'b1);
        tick();
        check("bp_empty", out_valid, 1'b0);

        // Flush while full with a taken jump presented
        out_ready = 1'b0;
        drive_alu(64'h1111, 5'd8);
        tick();
        drive_alu(64'h2222, 5'd9);
        tick();
        check("fl_full_in_ready", in_ready, 1'b0);
        idle();
        flush = 1'b1; in_valid = 1'b1; is_jump = 1'b1; pc = 64'h5000; target = 64'h6000;
        tick();
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_redirect", redirect, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        check("fl_redirect_pc", redirect_pc, 64'h4000);
        // Flush wins over a would-be accept from EMPTY
        tick();
        check("fl2_out_valid", out_valid, 1'b0);
        check("fl2_redirect", redirect, 1'b0);
        idle();
        out_ready = 1'b1;
        tick();
        check("fl_after_valid", out_valid, 1'b0);
        check("fl_after_redirect", redirect, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
